stream_mux2_1: RTL and testbench

- Merges two valid/ready source streams into one output stream. This is the gather counterpart to the 1:2 demux, which steers one stream to two sinks by `sel`.
- Sources compete under round-robin arbitration. The winning beat is captured in a one-entry output register.
- `out_sel` reports the originating source, so a downstream demux1_2-style stage can route the beat back by the same `sel` encoding (0 = y0/in0, 1 = y1/in1).
- Sits between two producers and a single shared consumer channel.

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/rr_arb2.sv | 38 +++
 rtl/stream_mux2_1.sv | 124 ++++++++++++
 tb/tb_stream_mux2_1.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the 2:1 stream gather path.
// The source indices use the same encoding as the 1:2 demux `sel` input,
// so out_sel can drive a downstream demux directly.
package stream_mux_pkg;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // State of the one-entry output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. It owns the priority bit.
// gnt is a per-source ready offer and does not depend on that source's own
// request. A transfer is gnt & req, and at most one bit of gnt & req is set.
module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic       prio;
    logic [1:0] xfer;

    // Offer a slot to the priority source, or to either source while the other is idle.
    always_comb begin
        gnt = 2'b00;
        if (en && !rst) begin
            gnt[0] = (prio == SRC0) || !req[1];
            gnt[1] = (prio == SRC1) || !req[0];
        end
        xfer    = gnt & req;
        gnt_idx = xfer[1] ? SRC1 : SRC0;
    end

    // After every transfer, hand priority to the source that did not win.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= SRC0;
        end else if (|xfer) begin
            prio <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux2_1.sv
// 2:1 valid/ready stream gather with a one-entry registered output.
// Round-robin arbitration decides which source loads the output register.
// out_sel tags each beat with its source so a demux can route it back.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | output register empty, out_valid=0
// ST_FULL  | output register holds a beat, out_valid=1
module stream_mux2_1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic       can_load;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       xfer0;
    logic       xfer1;
    logic       load;

    // out_ready reaches the source readys only through can_load.
    // An empty register always accepts. A full one accepts only while it drains this cycle.
    always_comb begin
        can_load = (state == ST_EMPTY) || out_ready;
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({in1_valid, in0_valid}),
        .en      (can_load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Source handshakes and the resulting register load.
    always_comb begin
        in0_ready = gnt[0];
        in1_ready = gnt[1];
        xfer0     = in0_valid && in0_ready;
        xfer1     = in1_valid && in1_ready;
        load      = xfer0 || xfer1;
    end

    // State register of the output-register FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. A drain with a simultaneous load stays FULL (back-to-back).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: begin
                if (load) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !load) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // out_valid comes straight from the state register, so it is glitch-free.
    always_comb begin
        out_valid = (state == ST_FULL);
    end

    // Payload and source tag. They hold while no load occurs, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= SRC0;
        end else if (load) begin
            out_data <= (gnt_idx == SRC1) ? in1_data : in0_data;
            out_sel  <= gnt_idx;
        end
    end

    // Per-source accepted-beat counters. They saturate and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (xfer0 && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (xfer1 && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux2_1.sv
// Directed bench for stream_mux2_1.
// Inputs change 1 ns after a rising edge. Ready outputs are checked before the next edge.
// Registered outputs are checked 1 ns after the edge.
module tb_stream_mux2_1;

    logic       clk;
    logic       rst;
    logic [7:0] in0_data, in1_data, out_data;
    logic       in0_valid, in0_ready, in1_valid, in1_ready;
    logic       out_sel, out_valid, out_ready;
    logic [15:0] cnt0, cnt1;

    // Second instance with 2-bit counters for the saturation check.
    logic [7:0] s_in0_data, s_in1_data, s_out_data;
    logic       s_in0_valid, s_in0_ready, s_in1_valid, s_in1_ready;
    logic       s_out_sel, s_out_valid, s_out_ready;
    logic [1:0] s_cnt0, s_cnt1;

    int checks = 0;
    int errors = 0;

    stream_mux2_1 #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    stream_mux2_1 #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in0_data(s_in0_data), .in0_valid(s_in0_valid), .in0_ready(s_in0_ready),
        .in1_data(s_in1_data), .in1_valid(s_in1_valid), .in1_ready(s_in1_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        check({tag, ".data"}, {24'b0, out_data}, {24'b0, d});
        check({tag, ".sel"}, {31'b0, out_sel}, {31'b0, s});
    endtask

    initial begin
        rst = 1'b1;
        in0_data = 8'hA0; in1_data = 8'hB0;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        s_in0_data = 8'h00; s_in1_data = 8'h00;
        s_in0_valid = 1'b0; s_in1_valid = 1'b0; s_out_ready = 1'b1;

        // Reset held for 2 cycles with both sources valid.
        cyc();
        cyc();
        check_out("rst", 1'b0, 8'h00, 1'b0);
        check("rst.in0_ready", {31'b0, in0_ready}, 0);
        check("rst.in1_ready", {31'b0, in1_ready}, 0);
        check("rst.cnt0", {16'b0, cnt0}, 0);
        check("rst.cnt1", {16'b0, cnt1}, 0);
        rst = 1'b0;
        #1;
        check("post_rst.in0_ready", {31'b0, in0_ready}, 1);
        check("post_rst.in1_ready", {31'b0, in1_ready}, 0);
        cyc();
        check_out("post_rst.first", 1'b1, 8'hA0, 1'b0);

        // A lone source streams 0x11, 0x22, 0x33 back-to-back.
        in0_valid = 1'b0; in1_valid = 1'b0;
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11;
        #1;
        check("single.in0_ready", {31'b0, in0_ready}, 1);
        cyc();
        check_out("single.b0", 1'b1, 8'h11, 1'b0);
        in0_data = 8'h22;
        cyc();
        check_out("single.b1", 1'b1, 8'h22, 1'b0);
        in0_data = 8'h33;
        cyc();
        check_out("single.b2", 1'b1, 8'h33, 1'b0);
        check("single.cnt0", {16'b0, cnt0}, 3);
        check("single.cnt1", {16'b0, cnt1}, 0);
        in0_valid = 1'b0;
        cyc();
        check("single.drain", {31'b0, out_valid}, 0);

        // Both sources valid: the grant strictly alternates, starting with in0.
        do_reset();
        in0_data = 8'hA0; in1_data = 8'hB0;
        in0_valid = 1'b1; in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_out($sformatf("cont.b%0d", i), 1'b1, (i % 2 == 0) ? 8'hA0 : 8'hB0, 1'(i % 2));
            check($sformatf("cont.cnt0_%0d", i), {16'b0, cnt0}, 32'(i / 2 + 1));
            check($sformatf("cont.cnt1_%0d", i), {16'b0, cnt1}, 32'((i + 1) / 2));
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        cyc();
        check("cont.drain", {31'b0, out_valid}, 0);

        // Backpressure: 0x5C from in1 is held while out_ready is low.
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h5C;
        cyc();
        check_out("bp.load", 1'b1, 8'h5C, 1'b1);
        in1_valid = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h66;
        out_ready = 1'b0;
        #1;
        check("bp.in0_ready", {31'b0, in0_ready}, 0);
        check("bp.in1_ready", {31'b0, in1_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_out($sformatf("bp.hold%0d", i), 1'b1, 8'h5C, 1'b1);
            check($sformatf("bp.rdy0_%0d", i), {31'b0, in0_ready}, 0);
            check($sformatf("bp.rdy1_%0d", i), {31'b0, in1_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", {31'b0, in0_ready}, 1);
        cyc();
        check_out("bp.next", 1'b1, 8'h66, 1'b0);
        check("bp.cnt0", {16'b0, cnt0}, 1);
        check("bp.cnt1", {16'b0, cnt1}, 1);
        in0_valid = 1'b0;
        cyc();
        check("bp.drain", {31'b0, out_valid}, 0);

        // Reset while FULL with 0x7E and out_ready low discards the beat.
        do_reset();
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h7E;
        cyc();
        check_out("midrst.full", 1'b1, 8'h7E, 1'b0);
        in0_valid = 1'b0;
        cyc();
        check_out("midrst.hold", 1'b1, 8'h7E, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_out("midrst.clear", 1'b0, 8'h00, 1'b0);
        check("midrst.cnt0", {16'b0, cnt0}, 0);
        out_ready = 1'b1;
        in0_data = 8'hA0; in1_data = 8'hB0;
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        check("midrst.prio0", {31'b0, in0_ready}, 1);
        check("midrst.prio1", {31'b0, in1_ready}, 0);
        cyc();
        check_out("midrst.after", 1'b1, 8'hA0, 1'b0);
        in0_valid = 1'b0; in1_valid = 1'b0;

        // With CNT_W=2, cnt0 saturates at 3.
        do_reset();
        s_in0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in0_data = 8'(i + 1);
            cyc();
            check($sformatf("sat.cnt0_%0d", i), {30'b0, s_cnt0}, (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("sat.cnt1", {30'b0, s_cnt1}, 0);
        check("sat.data", {24'b0, s_out_data}, 5);
        s_in0_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
